// File: rtl/mp3_play_ctrl_pkg.sv
// Shared definitions for the MP3 playback control front end: FSM encoding,
// default volume constants and the level-to-SCI_VOL mapping.
package mp3_play_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam int ATT_STEP_DEF   = 16;
  localparam int VOL_LEVELS_DEF = 16;

  localparam int BTN_NEXT   = 0;
  localparam int BTN_PREV   = 1;
  localparam int BTN_VOLUP  = 2;
  localparam int BTN_VOLDN  = 3;
  localparam int BTN_REPLAY = 4;

  // Same attenuation on both channels; the product wraps to 8 bits.
  function automatic logic [15:0] vol_from_level(input logic [3:0] lvl, input int att);
    logic [7:0] a;
    a = 8'((15 - int'(lvl)) * att);
    return {a, a};
  endfunction

endpackage

// File: rtl/mp3_play_ctrl_if.sv
// Engine-facing bundle: song select, volume, restart request and status.
interface mp3_play_ctrl_if;
  logic [4:0]  current;
  logic [15:0] vol;
  logic [3:0]  level;
  logic        iState;
  logic        busy;

  modport master (output current, vol, level, iState, busy);
  modport slave  (input  current, vol, level, iState, busy);
endinterface

// File: rtl/mp3_play_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, and a
// one-cycle press strobe on the accepted 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic clk_div,
  input  logic RST,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_settled;

  // Strobe is combinational so the caller acts on the same edge the level flips.
  assign w_settled = (r_s2 != r_level) && (r_cnt == CNT_LAST);
  assign press     = w_settled && r_s2;
  assign level     = r_level;

  always_ff @(posedge clk_div) begin
    if (!RST) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (w_settled) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mp3_play_ctrl.sv
// User control for the VS1003B engine: debounced buttons drive song index and
// volume, and each accepted change raises one restart pulse on iState.
module mp3_play_ctrl
  import mp3_play_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20000,
  parameter int SONG_NUM     = 8,
  parameter int VOL_LEVELS   = VOL_LEVELS_DEF,
  parameter int DEF_LEVEL    = 8,
  parameter int ATT_STEP     = ATT_STEP_DEF,
  parameter int PULSE_LEN    = 4,
  parameter int HOLDOFF      = 1000
) (
  input  logic            clk_div,
  input  logic            RST,
  input  logic            btn_next,
  input  logic            btn_prev,
  input  logic            btn_vol_up,
  input  logic            btn_vol_dn,
  input  logic            btn_replay,
  mp3_play_ctrl_if.master eng
);

  localparam int CNT_MAX = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF - 1);
  localparam logic [4:0]    SONG_LAST  = 5'(SONG_NUM - 1);
  localparam logic [3:0]    LVL_MAX    = 4'(VOL_LEVELS - 1);
  localparam logic [3:0]    LVL_DEF    = 4'(DEF_LEVEL);

  logic [4:0]    w_raw;
  logic [4:0]    w_press;
  logic          w_next;
  logic          w_prev;
  logic          w_up;
  logic          w_dn;
  logic          w_accept;

  logic [4:0]    r_current;
  logic [3:0]    r_level;
  logic [15:0]   r_vol;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_istate;
  logic          r_busy;
  logic          r_pending;

  assign w_raw = {btn_replay, btn_vol_dn, btn_vol_up, btn_prev, btn_next};

  for (genvar g = 0; g < 5; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
      .clk_div (clk_div),
      .RST     (RST),
      .raw     (w_raw[g]),
      .level   (),
      .press   (w_press[g])
    );
  end

  // Opposing presses in one cycle cancel; a saturated volume press is dropped.
  assign w_next   = w_press[BTN_NEXT]  & ~w_press[BTN_PREV];
  assign w_prev   = w_press[BTN_PREV]  & ~w_press[BTN_NEXT];
  assign w_up     = w_press[BTN_VOLUP] & ~w_press[BTN_VOLDN] & (r_level != LVL_MAX);
  assign w_dn     = w_press[BTN_VOLDN] & ~w_press[BTN_VOLUP] & (r_level != 4'd0);
  assign w_accept = w_next | w_prev | w_up | w_dn | w_press[BTN_REPLAY];

  always_ff @(posedge clk_div) begin
    if (!RST) begin
      r_current <= '0;
      r_level   <= LVL_DEF;
      r_vol     <= vol_from_level(LVL_DEF, ATT_STEP);
    end else begin
      if (w_next) begin
        r_current <= (r_current == SONG_LAST) ? 5'd0 : r_current + 5'd1;
      end else if (w_prev) begin
        r_current <= (r_current == 5'd0) ? SONG_LAST : r_current - 5'd1;
      end
      if (w_up) begin
        r_level <= r_level + 4'd1;
        r_vol   <= vol_from_level(r_level + 4'd1, ATT_STEP);
      end else if (w_dn) begin
        r_level <= r_level - 4'd1;
        r_vol   <= vol_from_level(r_level - 4'd1, ATT_STEP);
      end
    end
  end

  // Requests arriving while busy collapse into the single pending flag.
  always_ff @(posedge clk_div) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_istate  <= 1'b0;
      r_busy    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && r_pending) begin
        r_pending <= 1'b0;
      end else if (w_accept) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_pending) begin
            r_istate <= 1'b1;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_state  <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (r_cnt == PULSE_LAST) begin
            r_istate <= 1'b0;
            r_cnt    <= '0;
            r_state  <= ST_HOLDOFF;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (r_cnt == HOLD_LAST) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_istate <= 1'b0;
          r_busy   <= 1'b0;
          r_cnt    <= '0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign eng.current = r_current;
  assign eng.level   = r_level;
  assign eng.vol     = r_vol;
  assign eng.iState  = r_istate;
  assign eng.busy    = r_busy;

endmodule

// File: tb/tb_mp3_play_ctrl.sv
// Directed bench for mp3_play_ctrl with short debounce/pulse/holdoff timing.
module tb_mp3_play_ctrl;

  localparam logic [4:0] M_NEXT   = 5'b00001;
  localparam logic [4:0] M_PREV   = 5'b00010;
  localparam logic [4:0] M_UP     = 5'b00100;
  localparam logic [4:0] M_DN     = 5'b01000;
  localparam logic [4:0] M_REPLAY = 5'b10000;

  logic       clk_div = 1'b0;
  logic       RST     = 1'b0;
  logic [4:0] r_btn   = '0;

  int n_vec = 0;
  int n_err = 0;

  int cyc = 0, n_rise = 0, hi_cnt = 0, last_hi = 0, fall_cyc = 0, busy_gap = 0;
  logic p_is = 1'b0, p_busy = 1'b0;

  mp3_play_ctrl_if eng();

  mp3_play_ctrl #(
    .DEBOUNCE_CYC (4),
    .SONG_NUM     (8),
    .VOL_LEVELS   (16),
    .DEF_LEVEL    (8),
    .ATT_STEP     (16),
    .PULSE_LEN    (2),
    .HOLDOFF      (8)
  ) dut (
    .clk_div    (clk_div),
    .RST        (RST),
    .btn_next   (r_btn[0]),
    .btn_prev   (r_btn[1]),
    .btn_vol_up (r_btn[2]),
    .btn_vol_dn (r_btn[3]),
    .btn_replay (r_btn[4]),
    .eng        (eng)
  );

  always #5 clk_div = ~clk_div;

  always @(negedge clk_div) begin
    cyc = cyc + 1;
    if (eng.iState && !p_is) n_rise = n_rise + 1;
    if (eng.iState) hi_cnt = hi_cnt + 1;
    if (!eng.iState && p_is) begin
      last_hi  = hi_cnt;
      hi_cnt   = 0;
      fall_cyc = cyc;
    end
    if (!eng.busy && p_busy) busy_gap = cyc - fall_cyc;
    p_is   = eng.iState;
    p_busy = eng.busy;
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_vol(input int lvl);
    logic [7:0] a;
    a = 8'((15 - lvl) * 16);
    return {16'h0, a, a};
  endfunction

  task automatic press(input logic [4:0] m);
    @(negedge clk_div);
    r_btn = m;
    repeat (8) @(negedge clk_div);
    r_btn = '0;
    repeat (22) @(negedge clk_div);
  endtask

  initial begin
    int p0;
    logic got;
    logic was;

    // Reset values
    RST = 1'b0;
    repeat (3) @(negedge clk_div);
    chk_val("rst_current", eng.current, 0);
    chk_val("rst_level",   eng.level,   8);
    chk_val("rst_vol",     eng.vol,     32'h7070);
    chk_val("rst_iState",  eng.iState,  0);
    chk_val("rst_busy",    eng.busy,    0);
    RST = 1'b1;
    repeat (3) @(negedge clk_div);

    // Reset asserted while iState is high
    r_btn = M_NEXT;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_div);
      if (eng.iState) begin
        got = 1'b1;
        break;
      end
    end
    chk_val("midrst_pulse_seen", got, 1);
    RST   = 1'b0;
    r_btn = '0;
    @(negedge clk_div);
    chk_val("midrst_iState",  eng.iState,  0);
    chk_val("midrst_busy",    eng.busy,    0);
    chk_val("midrst_current", eng.current, 0);
    RST = 1'b1;
    repeat (12) @(negedge clk_div);

    // Bouncy next press: one strobe, one pulse
    p0 = n_rise;
    r_btn = M_NEXT; @(negedge clk_div);
    r_btn = '0;     @(negedge clk_div);
    r_btn = M_NEXT;
    repeat (8) @(negedge clk_div);
    r_btn = '0;
    repeat (25) @(negedge clk_div);
    chk_val("bounce_current", eng.current, 1);
    chk_val("bounce_pulses",  n_rise - p0, 1);
    chk_val("bounce_hi_len",  last_hi, 2);
    chk_val("bounce_busy_gap", busy_gap, 8);
    chk_val("bounce_idle",    {eng.iState, eng.busy}, 0);

    // Song wrap in both directions
    press(M_PREV);
    chk_val("prev_1to0", eng.current, 0);
    press(M_PREV);
    chk_val("prev_wrap", eng.current, 7);
    p0 = n_rise;
    press(M_NEXT);
    chk_val("next_wrap", eng.current, 0);
    chk_val("next_wrap_pulse", n_rise - p0, 1);

    // Volume up to saturation
    for (int k = 1; k <= 8; k++) begin
      p0 = n_rise;
      press(M_UP);
      chk_val($sformatf("volup%0d_level", k), eng.level, (8 + k > 15) ? 15 : 8 + k);
      chk_val($sformatf("volup%0d_vol", k), eng.vol, exp_vol((8 + k > 15) ? 15 : 8 + k));
      chk_val($sformatf("volup%0d_pulses", k), n_rise - p0, (k < 8) ? 1 : 0);
    end
    chk_val("vol_max", eng.vol, 32'h0000);

    // Opposing song presses cancel
    p0 = n_rise;
    press(M_NEXT | M_PREV);
    chk_val("pair_current", eng.current, 0);
    chk_val("pair_pulses",  n_rise - p0, 0);
    press(M_DN);
    chk_val("voldn_level", eng.level, 14);
    chk_val("voldn_vol",   eng.vol,   32'h1010);
    p0 = n_rise;
    press(M_UP | M_NEXT);
    chk_val("combo_current", eng.current, 1);
    chk_val("combo_level",   eng.level,   15);
    chk_val("combo_vol",     eng.vol,     32'h0000);
    chk_val("combo_pulses",  n_rise - p0, 1);

    // Presses during HOLDOFF merge into one further request
    p0 = n_rise;
    @(negedge clk_div);
    r_btn = M_PREV;
    got = 1'b0;
    was = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_div);
      if (i == 8) r_btn = '0;
      if (was && !eng.iState) begin
        got = 1'b1;
        break;
      end
      was = eng.iState;
    end
    chk_val("hold_fall_seen", got, 1);
    r_btn = M_NEXT;
    @(negedge clk_div);
    r_btn = M_NEXT | M_DN | M_REPLAY;
    repeat (8) @(negedge clk_div);
    r_btn = '0;
    repeat (30) @(negedge clk_div);
    chk_val("hold_current", eng.current, 1);
    chk_val("hold_level",   eng.level,   14);
    chk_val("hold_vol",     eng.vol,     32'h1010);
    chk_val("hold_pulses",  n_rise - p0, 2);
    chk_val("hold_idle",    {eng.iState, eng.busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
